// File: rtl/vx_cache_mem_arb.sv
// vx_cache_mem_arb: shares one memory bus between NUM_INPUTS cache memory ports.
// Requests are granted round-robin into a single output register. The winner's
// index goes into the low bits of the memory tag. Responses are steered back by
// decoding those bits.
module vx_cache_mem_arb #(
  parameter int NUM_INPUTS    = 4,
  parameter int ADDR_WIDTH    = 26,
  parameter int DATA_WIDTH    = 512,
  parameter int TAG_IN_WIDTH  = 8,
  parameter int IDX_WIDTH     = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 0,
  parameter int TAG_OUT_WIDTH = TAG_IN_WIDTH + IDX_WIDTH
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [NUM_INPUTS-1:0]                   in_req_valid,
  input  logic [NUM_INPUTS-1:0]                   in_req_rw,
  input  logic [NUM_INPUTS*ADDR_WIDTH-1:0]        in_req_addr,
  input  logic [NUM_INPUTS*(DATA_WIDTH/8)-1:0]    in_req_byteen,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0]        in_req_data,
  input  logic [NUM_INPUTS*TAG_IN_WIDTH-1:0]      in_req_tag,
  output logic [NUM_INPUTS-1:0]                   in_req_ready,
  output logic [NUM_INPUTS-1:0]                   in_rsp_valid,
  output logic [DATA_WIDTH-1:0]                   in_rsp_data,
  output logic [TAG_IN_WIDTH-1:0]                 in_rsp_tag,
  input  logic [NUM_INPUTS-1:0]                   in_rsp_ready,
  output logic                                    mem_req_valid,
  output logic                                    mem_req_rw,
  output logic [ADDR_WIDTH-1:0]                   mem_req_addr,
  output logic [DATA_WIDTH/8-1:0]                 mem_req_byteen,
  output logic [DATA_WIDTH-1:0]                   mem_req_data,
  output logic [TAG_OUT_WIDTH-1:0]                mem_req_tag,
  input  logic                                    mem_req_ready,
  input  logic                                    mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0]                   mem_rsp_data,
  input  logic [TAG_OUT_WIDTH-1:0]                mem_rsp_tag,
  output logic                                    mem_rsp_ready
);

  localparam int PTR_W = (IDX_WIDTH > 0) ? IDX_WIDTH : 1;
  localparam int BE_W  = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0]    addr_arr   [NUM_INPUTS];
  logic [BE_W-1:0]          byteen_arr [NUM_INPUTS];
  logic [DATA_WIDTH-1:0]    data_arr   [NUM_INPUTS];
  logic [TAG_IN_WIDTH-1:0]  tag_arr    [NUM_INPUTS];

  logic [PTR_W-1:0]         rr_ptr;
  logic [PTR_W-1:0]         grant_idx;
  logic [PTR_W-1:0]         scan_idx;
  logic                     grant_vld;
  int                       scan;
  logic                     stage_ready;
  logic                     load;
  logic [PTR_W-1:0]         rr_next;
  logic [TAG_OUT_WIDTH-1:0] tag_next;
  logic [PTR_W-1:0]         ridx;

  logic                     vld_p1;
  logic                     rw_p1;
  logic [ADDR_WIDTH-1:0]    addr_p1;
  logic [BE_W-1:0]          byteen_p1;
  logic [DATA_WIDTH-1:0]    data_p1;
  logic [TAG_OUT_WIDTH-1:0] tag_p1;

  for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_unpack
    assign addr_arr[i]   = in_req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign byteen_arr[i] = in_req_byteen[i*BE_W +: BE_W];
    assign data_arr[i]   = in_req_data[i*DATA_WIDTH +: DATA_WIDTH];
    assign tag_arr[i]    = in_req_tag[i*TAG_IN_WIDTH +: TAG_IN_WIDTH];
  end

  // Round-robin scan: first valid requester starting at rr_ptr, wrapping modulo NUM_INPUTS
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    scan      = 0;
    scan_idx  = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      scan = int'(rr_ptr) + i;
      if (scan >= NUM_INPUTS) scan = scan - NUM_INPUTS;
      scan_idx = PTR_W'(scan);
      if (!grant_vld && in_req_valid[scan_idx]) begin
        grant_vld = 1'b1;
        grant_idx = scan_idx;
      end
    end
  end

  // Reset gates acceptance so nothing is handshaken while the block is held in reset
  assign stage_ready  = reset && (!vld_p1 || mem_req_ready);
  assign load         = grant_vld && stage_ready;
  assign in_req_ready = load ? (NUM_INPUTS'(1) << grant_idx) : '0;
  assign rr_next      = (grant_idx == PTR_W'(NUM_INPUTS - 1)) ? '0 : grant_idx + PTR_W'(1);

  if (IDX_WIDTH > 0) begin : g_tag_idx
    assign tag_next    = {tag_arr[grant_idx], grant_idx};
    assign ridx        = mem_rsp_tag[IDX_WIDTH-1:0];
    assign in_rsp_tag  = mem_rsp_tag[TAG_OUT_WIDTH-1:IDX_WIDTH];
  end else begin : g_tag_pass
    assign tag_next    = tag_arr[0];
    assign ridx        = '0;
    assign in_rsp_tag  = mem_rsp_tag;
  end

  // ---- stage p0 (arbitration) -> p1 (registered memory request) ----
  // Output register: load the winner when the slot is free or draining; otherwise hold
  always_ff @(posedge clk) begin
    if (!reset) begin
      vld_p1    <= 1'b0;
      rr_ptr    <= '0;
      rw_p1     <= 1'b0;
      addr_p1   <= '0;
      byteen_p1 <= '0;
      data_p1   <= '0;
      tag_p1    <= '0;
    end else if (load) begin
      vld_p1    <= 1'b1;
      rr_ptr    <= rr_next;
      rw_p1     <= in_req_rw[grant_idx];
      addr_p1   <= addr_arr[grant_idx];
      byteen_p1 <= byteen_arr[grant_idx];
      data_p1   <= data_arr[grant_idx];
      tag_p1    <= tag_next;
    end else if (mem_req_ready) begin
      vld_p1    <= 1'b0;
    end
  end

  assign mem_req_valid  = vld_p1;
  assign mem_req_rw     = rw_p1;
  assign mem_req_addr   = addr_p1;
  assign mem_req_byteen = byteen_p1;
  assign mem_req_data   = data_p1;
  assign mem_req_tag    = tag_p1;

  // Stateless response steering by the index carried in the tag LSBs
  assign in_rsp_valid  = mem_rsp_valid ? (NUM_INPUTS'(1) << ridx) : '0;
  assign in_rsp_data   = mem_rsp_data;
  assign mem_rsp_ready = in_rsp_ready[ridx];

`ifndef SYNTHESIS
  a_req_stable: assert property (@(posedge clk) disable iff (!reset)
    (mem_req_valid && !mem_req_ready) |=> (mem_req_valid &&
      $stable({mem_req_rw, mem_req_addr, mem_req_byteen, mem_req_data, mem_req_tag})));
  a_ready_onehot: assert property (@(posedge clk) $onehot0(in_req_ready));
  a_ridx_legal: assert property (@(posedge clk) disable iff (!reset)
    mem_rsp_valid |-> (int'(ridx) < NUM_INPUTS));
`endif

endmodule

// File: tb/tb_vx_cache_mem_arb.sv
// Bench for vx_cache_mem_arb: per-cycle vector table for the request path,
// scoreboard on memory-side request handshakes, hand sequences for reset and responses.
module tb_vx_cache_mem_arb;

  localparam int N  = 4;
  localparam int AW = 26;
  localparam int DW = 512;
  localparam int TW = 8;
  localparam int TO = 10;

  logic             clk = 1'b0;
  logic             reset;
  logic [N-1:0]     in_req_valid;
  logic [N-1:0]     in_req_rw;
  logic [N*AW-1:0]  in_req_addr;
  logic [N*DW/8-1:0] in_req_byteen;
  logic [N*DW-1:0]  in_req_data;
  logic [N*TW-1:0]  in_req_tag;
  logic [N-1:0]     in_req_ready;
  logic [N-1:0]     in_rsp_valid;
  logic [DW-1:0]    in_rsp_data;
  logic [TW-1:0]    in_rsp_tag;
  logic [N-1:0]     in_rsp_ready;
  logic             mem_req_valid;
  logic             mem_req_rw;
  logic [AW-1:0]    mem_req_addr;
  logic [DW/8-1:0]  mem_req_byteen;
  logic [DW-1:0]    mem_req_data;
  logic [TO-1:0]    mem_req_tag;
  logic             mem_req_ready;
  logic             mem_rsp_valid;
  logic [DW-1:0]    mem_rsp_data;
  logic [TO-1:0]    mem_rsp_tag;
  logic             mem_rsp_ready;

  vx_cache_mem_arb #(.NUM_INPUTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAG_IN_WIDTH(TW)) dut (
    .clk(clk), .reset(reset),
    .in_req_valid(in_req_valid), .in_req_rw(in_req_rw), .in_req_addr(in_req_addr),
    .in_req_byteen(in_req_byteen), .in_req_data(in_req_data), .in_req_tag(in_req_tag),
    .in_req_ready(in_req_ready),
    .in_rsp_valid(in_rsp_valid), .in_rsp_data(in_rsp_data), .in_rsp_tag(in_rsp_tag),
    .in_rsp_ready(in_rsp_ready),
    .mem_req_valid(mem_req_valid), .mem_req_rw(mem_req_rw), .mem_req_addr(mem_req_addr),
    .mem_req_byteen(mem_req_byteen), .mem_req_data(mem_req_data), .mem_req_tag(mem_req_tag),
    .mem_req_ready(mem_req_ready),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .mem_rsp_tag(mem_rsp_tag),
    .mem_rsp_ready(mem_rsp_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] valid;
    logic       mrdy;
    logic [3:0] exp_rdy;
    logic       exp_mv;
    logic [9:0] exp_tag;
  } vec_t;

  typedef struct packed {
    logic [9:0]  tag;
    logic [25:0] addr;
    logic [31:0] data;
  } sb_t;

  vec_t vecs [19];
  sb_t  sbq [$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int g);
    sb_t e;
    e.tag  = {8'h05, 2'(g)};
    e.addr = 26'h121 + 26'(g);
    e.data = 32'hD000_0000 + 32'(g);
    sbq.push_back(e);
  endtask

  // Scoreboard: a request handshake is visible half a cycle before the edge that takes it
  always @(negedge clk) begin
    sb_t e;
    if (reset === 1'b1 && mem_req_valid === 1'b1 && mem_req_ready === 1'b1) begin
      if (sbq.size() == 0) begin
        chk("sb_unexpected_req", {54'd0, mem_req_tag}, 64'h3FF);
      end else begin
        e = sbq.pop_front();
        chk("sb_tag", {54'd0, mem_req_tag}, {54'd0, e.tag});
        chk("sb_addr", {38'd0, mem_req_addr}, {38'd0, e.addr});
        chk("sb_data", {32'd0, mem_req_data[31:0]}, {32'd0, e.data});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{4'b1111, 1'b1, 4'b0001, 1'b0, 10'h000};
    vecs[1]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 10'h014};
    vecs[2]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 10'h015};
    vecs[3]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 10'h016};
    vecs[4]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 10'h017};
    vecs[5]  = '{4'b0000, 1'b1, 4'b0000, 1'b1, 10'h014};
    vecs[6]  = '{4'b0100, 1'b0, 4'b0100, 1'b0, 10'h000};
    for (int k = 7; k <= 10; k++) vecs[k] = '{4'b0100, 1'b0, 4'b0000, 1'b1, 10'h016};
    vecs[11] = '{4'b0100, 1'b1, 4'b0100, 1'b1, 10'h016};
    vecs[12] = '{4'b0100, 1'b1, 4'b0100, 1'b1, 10'h016};
    vecs[13] = '{4'b0010, 1'b1, 4'b0010, 1'b1, 10'h016};
    vecs[14] = '{4'b1010, 1'b1, 4'b1000, 1'b1, 10'h015};
    vecs[15] = '{4'b1010, 1'b1, 4'b0010, 1'b1, 10'h017};
    vecs[16] = '{4'b1010, 1'b1, 4'b1000, 1'b1, 10'h015};
    vecs[17] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 10'h017};
    vecs[18] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 10'h000};

    for (int i = 0; i < N; i++) begin
      in_req_addr[i*AW +: AW] = 26'h121 + 26'(i);
      in_req_tag[i*TW +: TW]  = 8'h05;
      in_req_data[i*DW +: DW] = {16{32'hD000_0000 + 32'(i)}};
    end
    in_req_rw     = 4'b0101;
    in_req_byteen = '1;
    in_rsp_ready  = '0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    mem_rsp_tag   = '0;

    // Reset hold with every requester asserting valid
    reset         = 1'b0;
    in_req_valid  = 4'b1111;
    mem_req_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("rst_mem_valid", {63'd0, mem_req_valid}, 64'd0);
      chk("rst_in_ready", {60'd0, in_req_ready}, 64'd0);
      chk("rst_mem_tag", {54'd0, mem_req_tag}, 64'd0);
    end
    reset = 1'b1;

    // Request-path vector table, one entry per clock
    for (int v = 0; v < 19; v++) begin
      in_req_valid  = vecs[v].valid;
      mem_req_ready = vecs[v].mrdy;
      #1;
      chk($sformatf("v%0d_in_ready", v), {60'd0, in_req_ready}, {60'd0, vecs[v].exp_rdy});
      chk($sformatf("v%0d_mem_valid", v), {63'd0, mem_req_valid}, {63'd0, vecs[v].exp_mv});
      if (vecs[v].exp_mv) begin
        chk($sformatf("v%0d_mem_tag", v), {54'd0, mem_req_tag}, {54'd0, vecs[v].exp_tag});
        chk($sformatf("v%0d_mem_addr", v), {38'd0, mem_req_addr},
            {38'd0, 26'h121 + 26'(vecs[v].exp_tag[1:0])});
      end
      for (int g = 0; g < N; g++) if (vecs[v].exp_rdy[g]) push_exp(g);
      tick();
    end

    // Mid-operation reset while a request sits stalled in the output register
    in_req_valid  = 4'b0100;
    mem_req_ready = 1'b0;
    #1;
    chk("mr_load_ready", {60'd0, in_req_ready}, 64'h4);
    tick();
    in_req_valid = 4'b0000;
    #1;
    chk("mr_stalled_valid", {63'd0, mem_req_valid}, 64'd1);
    reset = 1'b0;
    tick();
    chk("mr_reset_valid", {63'd0, mem_req_valid}, 64'd0);
    reset         = 1'b1;
    mem_req_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick();
      chk("mr_no_stale", {63'd0, mem_req_valid}, 64'd0);
    end
    in_req_valid = 4'b1111;
    #1;
    chk("mr_ptr_zero_grant", {60'd0, in_req_ready}, 64'h1);
    push_exp(0);
    tick();
    in_req_valid = 4'b0000;
    #1;
    chk("mr_first_tag", {54'd0, mem_req_tag}, 64'h014);
    tick();
    chk("mr_drained", {63'd0, mem_req_valid}, 64'd0);

    // Response steering by tag index
    mem_rsp_valid = 1'b1;
    mem_rsp_tag   = 10'h02E;
    mem_rsp_data  = {16{32'hCAFE_0123}};
    in_rsp_ready  = 4'b0100;
    #1;
    chk("rsp_valid_idx2", {60'd0, in_rsp_valid}, 64'h4);
    chk("rsp_tag_idx2", {56'd0, in_rsp_tag}, 64'h0B);
    chk("rsp_ready_idx2", {63'd0, mem_rsp_ready}, 64'd1);
    chk("rsp_data", {32'd0, in_rsp_data[511:480]}, 64'hCAFE_0123);
    in_rsp_ready = 4'b1011;
    #1;
    chk("rsp_ready_blocked", {63'd0, mem_rsp_ready}, 64'd0);
    mem_rsp_tag  = 10'h3C7;
    in_rsp_ready = 4'b1000;
    #1;
    chk("rsp_valid_idx3", {60'd0, in_rsp_valid}, 64'h8);
    chk("rsp_tag_idx3", {56'd0, in_rsp_tag}, 64'hF1);
    chk("rsp_ready_idx3", {63'd0, mem_rsp_ready}, 64'd1);
    mem_rsp_valid = 1'b0;
    #1;
    chk("rsp_idle_valid", {60'd0, in_rsp_valid}, 64'h0);

    tick();
    chk("sb_leftover", 64'(sbq.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
